// File: rtl/scan_arb_pkg.sv
// Shared widths and helpers for the CCI-P c0 read-channel arbiter.
package scan_arb_pkg;

  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned CL_DATA_W = 512;
  localparam int unsigned MDATA_W   = 16;
  localparam int unsigned ID_W      = 3;
  localparam int unsigned CREDIT_W  = 4;
  localparam int unsigned STAT_W    = 32;

  // Requester id lives in the low mdata bits; upper bits stay zero so stray tags are detectable.
  function automatic logic [MDATA_W-1:0] make_mdata(input logic [ID_W-1:0] id);
    return MDATA_W'(id);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
module rr_arbiter
  import scan_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  always_comb begin
    logic found;
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (i_enable && !found && i_eligible[j] &&
            (((32'(i_ptr) + off) % NUM_REQ) == j)) begin
          o_grant[j]  = 1'b1;
          o_grant_idx = ID_W'(j);
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_rd_arbiter.sv
// Shares the CCI-P c0 read channel among scan engines with per-engine credits and tag-based response steering.
// Optional per-engine grant counters are enabled with SCAN_RD_ARB_STATS_EN.
module scan_rd_arbiter
  import scan_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*CL_ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           c0_alm_full,
  output logic                           c0_req_valid,
  output logic [CL_ADDR_W-1:0]           c0_req_addr,
  output logic [MDATA_W-1:0]             c0_req_mdata,
  input  logic                           c0_rsp_valid,
  input  logic [MDATA_W-1:0]             c0_rsp_mdata,
  input  logic [CL_DATA_W-1:0]           c0_rsp_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [CL_DATA_W-1:0]           rsp_data,
  output logic                           all_idle,
  output logic                           tag_err
`ifdef SCAN_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      grant_count
`endif
);

  logic [ID_W-1:0]     r_ptr;
  logic [CREDIT_W-1:0] r_credit [NUM_REQ];

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_grant_any;
  logic [CL_ADDR_W-1:0] w_grant_addr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     w_rsp_id;
  logic                w_rsp_tag_ok;
  logic [NUM_REQ-1:0]  w_rsp_hit;
  logic                w_rsp_bad;
  logic [CREDIT_W-1:0] w_credit_nxt [NUM_REQ];
  logic                w_idle_nxt;

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      w_eligible[j] = req_valid[j] && (r_credit[j] < CREDIT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .NUM_REQ     (NUM_REQ)
  ) u_rr_arbiter (
    .i_eligible  (w_eligible),
    .i_ptr       (r_ptr),
    .i_enable    (!c0_alm_full),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Grant is also the acceptance: eligibility already requires req_valid.
  assign req_ready   = w_grant;
  assign w_grant_any = |w_grant;

  always_comb begin
    w_grant_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_grant_addr = req_addr[j*CL_ADDR_W +: CL_ADDR_W];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_grant_any) begin
      w_ptr_nxt = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    end
  end

  // A response is only routed when its tag is well formed and the owner actually has a read in flight.
  assign w_rsp_id     = c0_rsp_mdata[ID_W-1:0];
  assign w_rsp_tag_ok = (c0_rsp_mdata[MDATA_W-1:ID_W] == '0);

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      w_rsp_hit[j] = c0_rsp_valid && w_rsp_tag_ok && (w_rsp_id == ID_W'(j)) &&
                     (r_credit[j] != '0);
    end
  end

  assign w_rsp_bad = c0_rsp_valid && !(|w_rsp_hit);

  always_comb begin
    w_credit_nxt = r_credit;
    w_idle_nxt   = !w_grant_any;
    for (int j = 0; j < NUM_REQ; j++) begin
      case ({w_grant[j], w_rsp_hit[j]})
        2'b10:   w_credit_nxt[j] = r_credit[j] + CREDIT_W'(1);
        2'b01:   w_credit_nxt[j] = r_credit[j] - CREDIT_W'(1);
        default: w_credit_nxt[j] = r_credit[j];
      endcase
      if (w_credit_nxt[j] != '0) begin
        w_idle_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        r_credit[j] <= '0;
      end
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      all_idle     <= 1'b1;
      tag_err      <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_credit     <= w_credit_nxt;
      all_idle     <= w_idle_nxt;
      c0_req_valid <= w_grant_any;
      rsp_valid    <= w_rsp_hit;
      if (w_grant_any) begin
        c0_req_addr  <= w_grant_addr;
        c0_req_mdata <= make_mdata(w_grant_idx);
      end
      if (|w_rsp_hit) begin
        rsp_data <= c0_rsp_data;
      end
      if (w_rsp_bad) begin
        tag_err <= 1'b1;
      end
    end
  end

`ifdef SCAN_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] r_grant_count;

  // Free-running profiling counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_count <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_grant[j]) begin
          r_grant_count[j] <= r_grant_count[j] + STAT_W'(1);
        end
      end
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule
